// File: rtl/data_mem_bridge_if.sv
// Core data-SRAM side and req/addr_ok/data_ok memory side of the bridge, bundled.
// Signal names keep the core's data_sram / memory-bus naming so the wiring reads 1:1.
interface data_mem_bridge_if;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic        bus_err;

  // master: the bridge itself
  modport master (
    input  cpu_en, cpu_wen, cpu_addr, cpu_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output cpu_rdata, cpu_stall,
    output mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
    output bus_err
  );

  // slave: the core plus memory environment around it
  modport slave (
    output cpu_en, cpu_wen, cpu_addr, cpu_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  cpu_rdata, cpu_stall,
    input  mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
    input  bus_err
  );
endinterface

// File: rtl/data_mem_bridge.sv
// Turns the core's single-cycle data-SRAM access into a two-phase req/addr_ok/data_ok bus access.
// mem_req one cycle after the request, DONE at least two cycles after it; cpu_stall holds the core until DONE.
module data_mem_bridge #(
  parameter bit MAP_EN  = 1'b1,
  parameter int TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  data_mem_bridge_if.master bus
);

  localparam int WDW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state;
  logic            memReq;
  logic            memWr;
  logic [1:0]      memSize;
  logic [31:0]     memAddr;
  logic [31:0]     memWdata;
  logic [31:0]     cpuRdata;
  logic            busErr;
  logic [WDW-1:0]  wdog;
  logic [31:0]     physAddr;
  logic            isRead;

  // Partial strobes that are not a clean byte or halfword go out as a full word.
  function automatic logic [1:0] sizeOf(input logic [3:0] wen);
    logic [1:0] sz;
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: sz = 2'd0;
      4'b0011, 4'b1100:                   sz = 2'd1;
      default:                            sz = 2'd2;
    endcase
    return sz;
  endfunction

  // kseg0/kseg1 both fold onto the low 512 MB; everything else is already physical.
  function automatic logic [31:0] xlate(input logic [31:0] va);
    logic [31:0] pa;
    if (MAP_EN && (va[31:30] == 2'b10)) begin
      pa = va & 32'h1FFF_FFFF;
    end else begin
      pa = va;
    end
    return pa;
  endfunction

  assign physAddr = xlate(bus.cpu_addr);
  assign isRead   = (bus.cpu_wen == 4'b0000);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      memReq   <= 1'b0;
      memWr    <= 1'b0;
      memSize  <= 2'd0;
      memAddr  <= 32'h0;
      memWdata <= 32'h0;
      cpuRdata <= 32'h0;
      busErr   <= 1'b0;
      wdog     <= '0;
    end else begin
      // Watchdog only flags the stall; the access keeps waiting for the bus.
      if ((state == S_REQ) || (state == S_WAIT)) begin
        if (wdog != WD_MAX) begin
          wdog <= wdog + WDW'(1);
        end
        if (wdog == WD_LAST) begin
          busErr <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (bus.cpu_en) begin
            memReq   <= 1'b1;
            memWr    <= !isRead;
            memSize  <= sizeOf(bus.cpu_wen);
            memAddr  <= isRead ? {physAddr[31:2], 2'b00} : physAddr;
            memWdata <= bus.cpu_wdata;
            wdog     <= '0;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.mem_addr_ok) begin
            memReq <= 1'b0;
            if (bus.mem_data_ok) begin
              if (!memWr) begin
                cpuRdata <= bus.mem_rdata;
              end
              state <= S_DONE;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus.mem_data_ok) begin
            if (!memWr) begin
              cpuRdata <= bus.mem_rdata;
            end
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Dropping stall in DONE lets the core advance on that edge and present its next access in IDLE.
  assign bus.cpu_stall = bus.cpu_en & (state != S_DONE);
  assign bus.cpu_rdata = cpuRdata;
  assign bus.mem_req   = memReq;
  assign bus.mem_wr    = memWr;
  assign bus.mem_size  = memSize;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign bus.bus_err   = busErr;

endmodule
